// File: rtl/digit_pulse_generator_if.sv
// Control/status bundle of the digit pulse generator.
//   start, stop_req, run_one : one-clk control pulses from the starter / stop_one logic
//   d                        : one-hot digit pulses d0..d[NUM_DIGITS-1]
//   g1_pos, g1_neg           : odd/even minor-cycle gate (complementary)
//   mc_start, mc_end         : minor-cycle boundary strobes
//   running                  : digit pulses are being generated
//   mc_count                 : completed minor cycles since reset (wraps)
//   state_dbg                : FSM state (0 IDLE, 1 RUN, 2 LAST) for observation
// Handshake: there is no valid/ready pair. Each control input is a single-clk
// pulse that is acted on in the clk it is sampled and is never held off.
// Outputs are registered and valid every clk.
interface digit_pulse_generator_if #(
    parameter int NUM_DIGITS = 36
);
    logic                  start;
    logic                  stop_req;
    logic                  run_one;
    logic [NUM_DIGITS-1:0] d;
    logic                  g1_pos;
    logic                  g1_neg;
    logic                  mc_start;
    logic                  mc_end;
    logic                  running;
    logic [15:0]           mc_count;
    logic [1:0]            state_dbg;

    modport master (
        output start, stop_req, run_one,
        input  d, g1_pos, g1_neg, mc_start, mc_end, running, mc_count, state_dbg
    );

    modport slave (
        input  start, stop_req, run_one,
        output d, g1_pos, g1_neg, mc_start, mc_end, running, mc_count, state_dbg
    );
endinterface

// File: rtl/digit_pulse_generator.sv
// Digit pulse generator: timing source producing one-hot digit pulses, the
// odd/even minor-cycle gate and minor-cycle boundary strobes, with run, stop
// and single-minor-cycle control that only ever halts on a minor-cycle boundary.
// Ports:
//   clk   : system clock
//   reset : synchronous, active-high reset
//   bus   : digit_pulse_generator_if.slave (controls in, pulses/status out)
module digit_pulse_generator #(
    parameter int NUM_DIGITS = 36,
    parameter int DIV        = 1
) (
    input  logic                    clk,
    input  logic                    reset,
    digit_pulse_generator_if.slave  bus
);
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int DIG_W = $clog2(NUM_DIGITS);
    localparam logic [DIV_W-1:0] DIV_MAX = DIV_W'(DIV - 1);
    localparam logic [DIG_W-1:0] DIG_MAX = DIG_W'(NUM_DIGITS - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_LAST = 2'd2
    } state_t;

    state_t                state, state_n;
    logic [DIV_W-1:0]      div_cnt, div_n;
    logic [DIG_W-1:0]      dig_cnt, dig_n;
    logic                  end_dp, end_mc, active, running_n;
    logic [NUM_DIGITS-1:0] d_q;
    logic                  g1_q, mc_start_q, mc_end_q, running_q;
    logic [15:0]           mc_count_q;

    // Counters always describe the digit being shown this clk; the outputs are
    // registered from the next-cycle values so they line up with the counters.
    always_comb begin
        end_dp  = (div_cnt == DIV_MAX);
        end_mc  = end_dp && (dig_cnt == DIG_MAX);
        active  = (state != S_IDLE);
        state_n = state;
        case (state)
            // stop_req beats both start requests; run_one beats start.
            S_IDLE: begin
                if (!bus.stop_req) begin
                    if (bus.run_one)    state_n = S_LAST;
                    else if (bus.start) state_n = S_RUN;
                end
            end
            // A stop arriving on the very last clk of a minor cycle halts right
            // at that boundary instead of running one more cycle.
            S_RUN: begin
                if (end_mc && bus.stop_req)          state_n = S_IDLE;
                else if (bus.stop_req || bus.run_one) state_n = S_LAST;
            end
            S_LAST: begin
                if (end_mc) state_n = S_IDLE;
            end
            default: state_n = S_IDLE;
        endcase

        // Counters are held at 0 in IDLE and wrap to 0 at every minor-cycle
        // end, so a restart always begins with a full-length d0.
        div_n = '0;
        dig_n = '0;
        if (active && !end_mc) begin
            div_n = end_dp ? '0 : div_cnt + 1'b1;
            dig_n = end_dp ? dig_cnt + 1'b1 : dig_cnt;
        end
        running_n = (state_n != S_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= S_IDLE;
            div_cnt    <= '0;
            dig_cnt    <= '0;
            d_q        <= '0;
            g1_q       <= 1'b0;
            mc_start_q <= 1'b0;
            mc_end_q   <= 1'b0;
            running_q  <= 1'b0;
            mc_count_q <= '0;
        end else begin
            state      <= state_n;
            div_cnt    <= div_n;
            dig_cnt    <= dig_n;
            running_q  <= running_n;
            d_q        <= running_n ? (NUM_DIGITS'(1) << dig_n) : '0;
            mc_start_q <= running_n && (dig_n == '0) && (div_n == '0);
            mc_end_q   <= running_n && (dig_n == DIG_MAX) && (div_n == DIV_MAX);
            // Parity flips on the boundary edge, so the new value appears with
            // the next d0; it is kept through IDLE.
            if (active && end_mc) begin
                mc_count_q <= mc_count_q + 16'd1;
                g1_q       <= ~g1_q;
            end
        end
    end

    assign bus.d         = d_q;
    assign bus.g1_pos    = g1_q;
    assign bus.g1_neg    = ~g1_q;
    assign bus.mc_start  = mc_start_q;
    assign bus.mc_end    = mc_end_q;
    assign bus.running   = running_q;
    assign bus.mc_count  = mc_count_q;
    assign bus.state_dbg = state;
endmodule
